imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/imem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates a fetch read port and a program-loader write port onto one instruction memory.
// Define IMEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the loader wins ties.
module imem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic        owner_ld_q, owner_ld_d;
  logic        sel_ld;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic        last_ld_q, last_ld_d;

  // On a tie, the side that did not win last time gets the grant.
  assign sel_ld = ld_req & (~fetch_req | ~last_ld_q);
`else
  assign sel_ld = ld_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_ld_d   = owner_ld_q;
    fetch_data_d = fetch_data_q;
    fetch_gnt    = 1'b0;
    ld_gnt       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    fetch_valid  = 1'b0;
    ld_done      = 1'b0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    last_ld_d    = last_ld_q;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_req || ld_req) begin
          owner_ld_d = sel_ld;
          addr_d     = sel_ld ? ld_addr : fetch_addr;
          wdata_d    = ld_wdata;
          // Grants are combinational, so keep them quiet while reset is held.
          ld_gnt     = sel_ld & ~reset;
          fetch_gnt  = ~sel_ld & ~reset;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
          last_ld_d  = sel_ld;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = owner_ld_q;
        cnt_d   = 4'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!owner_ld_q) begin
            fetch_data_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        fetch_valid = ~owner_ld_q;
        ld_done     = owner_ld_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      fetch_data_q <= 32'd0;
      owner_ld_q   <= 1'b0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_ld_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fetch_data_q <= fetch_data_d;
      owner_ld_q   <= owner_ld_d;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_ld_q    <= last_ld_d;
`endif
    end
  end

  assign mem_addr   = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata  = wdata_q;
  assign fetch_data = fetch_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 (index 0) and one with MEM_LAT=3 (index 1),
// each with a small pipelined memory model.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [1:0]  fetch_req = '0, ld_req = '0;
  logic [1:0]  fetch_gnt, fetch_valid, ld_gnt, ld_done, mem_en, mem_we, busy;
  logic [31:0] fetch_addr [2];
  logic [31:0] ld_addr    [2];
  logic [31:0] ld_wdata   [2];
  logic [31:0] fetch_data [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [31:0] mem_arr [0:15];
      logic [31:0] pipe    [0:LAT-1];

      imem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req[gi]),
        .fetch_addr (fetch_addr[gi]),
        .fetch_gnt  (fetch_gnt[gi]),
        .fetch_valid(fetch_valid[gi]),
        .fetch_data (fetch_data[gi]),
        .ld_req     (ld_req[gi]),
        .ld_addr    (ld_addr[gi]),
        .ld_wdata   (ld_wdata[gi]),
        .ld_gnt     (ld_gnt[gi]),
        .ld_done    (ld_done[gi]),
        .mem_en     (mem_en[gi]),
        .mem_we     (mem_we[gi]),
        .mem_addr   (mem_addr[gi]),
        .mem_wdata  (mem_wdata[gi]),
        .mem_rdata  (mem_rdata[gi]),
        .busy       (busy[gi])
      );

      // Memory: word 0 = 003100B3, word k = A000000k; read data appears LAT cycles after mem_en.
      always @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < 16; k++)
            mem_arr[k] <= (k == 0) ? 32'h003100B3 : (32'hA000_0000 | 32'(k));
        end else if (mem_en[gi]) begin
          if (mem_we[gi]) mem_arr[mem_addr[gi][5:2]] <= mem_wdata[gi];
          pipe[0] <= mem_arr[mem_addr[gi][5:2]];
        end
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[gi] = pipe[LAT-1];
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_req = '0;
    ld_req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    fetch_req[0] = 1'b1;
    fetch_addr[0] = 32'h0;
    #1;
    checks++;
    if (fetch_gnt[0] !== 1'b0) begin
      errors++; $display("FAIL reset_gnt_gated: got %b expected 0", fetch_gnt[0]);
    end
    tick();
    fetch_req[0] = 1'b0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({fetch_gnt[i], ld_gnt[i], mem_en[i], mem_we[i], fetch_valid[i], ld_done[i], busy[i]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected 0000000", i,
                 {fetch_gnt[i], ld_gnt[i], mem_en[i], mem_we[i], fetch_valid[i], ld_done[i], busy[i]});
      end
      checks++;
      if (fetch_data[i] !== 32'h0) begin
        errors++; $display("FAIL reset_fetch_data[%0d]: got %h expected 00000000", i, fetch_data[i]);
      end
    end
    tick();
  endtask

  // obs bit order: fetch_gnt, ld_gnt, mem_en, mem_we, fetch_valid, ld_done, busy
  task automatic test_fetch_lat1();
    logic [6:0] exp_t [5];
    logic [6:0] obs;
    exp_t = '{7'b1000000, 7'b0010001, 7'b0000001, 7'b0000101, 7'b0000000};
    fetch_addr[0] = 32'h0;
    fetch_req[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) fetch_req[0] = 1'b0;
      #1;
      obs = {fetch_gnt[0], ld_gnt[0], mem_en[0], mem_we[0], fetch_valid[0], ld_done[0], busy[0]};
      checks++;
      if (obs !== exp_t[c]) begin
        errors++; $display("FAIL fetch_lat1 c%0d: got %b expected %b", c, obs, exp_t[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr[0] !== 32'h0) begin
          errors++; $display("FAIL fetch_lat1_addr: got %h expected 00000000", mem_addr[0]);
        end
      end
      if (c == 3) begin
        checks++;
        if (fetch_data[0] !== 32'h003100B3) begin
          errors++; $display("FAIL fetch_lat1_data: got %h expected 003100b3", fetch_data[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_lat3();
    logic [6:0] exp_l [7];
    logic [6:0] exp_f [7];
    logic [6:0] obs;
    exp_l = '{7'b0100000, 7'b0011001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000011, 7'b0000000};
    exp_f = '{7'b1000000, 7'b0010001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000101, 7'b0000000};
    ld_addr[1] = 32'h0000_000C;
    ld_wdata[1] = 32'h0000_4430;
    ld_req[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) ld_req[1] = 1'b0;
      #1;
      obs = {fetch_gnt[1], ld_gnt[1], mem_en[1], mem_we[1], fetch_valid[1], ld_done[1], busy[1]};
      checks++;
      if (obs !== exp_l[c]) begin
        errors++; $display("FAIL load_lat3 c%0d: got %b expected %b", c, obs, exp_l[c]);
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr[1], mem_wdata[1]} !== {32'h0000_000C, 32'h0000_4430}) begin
          errors++; $display("FAIL load_lat3_addr_wdata: got %h/%h expected 0000000c/00004430",
                             mem_addr[1], mem_wdata[1]);
        end
      end
      if (c == 5) begin
        checks++;
        if (fetch_data[1] !== 32'h0) begin
          errors++; $display("FAIL load_keeps_fetch_data: got %h expected 00000000", fetch_data[1]);
        end
      end
      tick();
    end
    fetch_addr[1] = 32'h0000_000E;
    fetch_req[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) fetch_req[1] = 1'b0;
      #1;
      obs = {fetch_gnt[1], ld_gnt[1], mem_en[1], mem_we[1], fetch_valid[1], ld_done[1], busy[1]};
      checks++;
      if (obs !== exp_f[c]) begin
        errors++; $display("FAIL fetch_lat3 c%0d: got %b expected %b", c, obs, exp_f[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr[1] !== 32'h0000_000C) begin
          errors++; $display("FAIL fetch_lat3_addr: got %h expected 0000000c", mem_addr[1]);
        end
      end
      if (c == 5) begin
        checks++;
        if (fetch_data[1] !== 32'h0000_4430) begin
          errors++; $display("FAIL fetch_lat3_data: got %h expected 00004430", fetch_data[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_tie();
    logic [11:0] exp_fg, exp_lg;
    int drop_ld, drop_f;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    exp_fg = 12'b0001_0000_0001;
    exp_lg = 12'b0000_0001_0000;
    drop_ld = 9;
    drop_f = 9;
`else
    exp_fg = 12'b0000_0001_0000;
    exp_lg = 12'b0000_0000_0001;
    drop_ld = 1;
    drop_f = 5;
`endif
    do_reset();
    fetch_addr[0] = 32'h0000_0008;
    ld_addr[0] = 32'h0000_003C;
    ld_wdata[0] = 32'hDEAD_BEEF;
    fetch_req[0] = 1'b1;
    ld_req[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == drop_ld) ld_req[0] = 1'b0;
      if (c == drop_f) fetch_req[0] = 1'b0;
      #1;
      checks++;
      if ({fetch_gnt[0], ld_gnt[0]} !== {exp_fg[c], exp_lg[c]}) begin
        errors++; $display("FAIL tie c%0d: got fetch_gnt/ld_gnt %b%b expected %b%b",
                           c, fetch_gnt[0], ld_gnt[0], exp_fg[c], exp_lg[c]);
      end
      tick();
    end
    fetch_req[0] = 1'b0;
    ld_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_busy_hold();
    logic [6:0] exp_t [8];
    logic [6:0] obs;
    exp_t = '{7'b0100000, 7'b0011001, 7'b0000001, 7'b0000011,
              7'b1000000, 7'b0010001, 7'b0000001, 7'b0000101};
    ld_addr[0] = 32'h0000_0020;
    ld_wdata[0] = 32'h1234_5678;
    fetch_addr[0] = 32'h0000_0004;
    ld_req[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) ld_req[0] = 1'b0;
      if (c == 2) fetch_req[0] = 1'b1;
      if (c == 5) fetch_req[0] = 1'b0;
      #1;
      obs = {fetch_gnt[0], ld_gnt[0], mem_en[0], mem_we[0], fetch_valid[0], ld_done[0], busy[0]};
      checks++;
      if (obs !== exp_t[c]) begin
        errors++; $display("FAIL busy_hold c%0d: got %b expected %b", c, obs, exp_t[c]);
      end
      if (c == 3) begin
        checks++;
        if (fetch_data[0] !== 32'hA000_0002) begin
          errors++; $display("FAIL busy_hold_keep_data: got %h expected a0000002", fetch_data[0]);
        end
      end
      if (c == 7) begin
        checks++;
        if (fetch_data[0] !== 32'hA000_0001) begin
          errors++; $display("FAIL busy_hold_data: got %h expected a0000001", fetch_data[0]);
        end
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_wait();
    fetch_addr[0] = 32'h0;
    fetch_req[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 1) fetch_req[0] = 1'b0;
      if (c == 2) reset = 1'b1;
      if (c == 3) reset = 1'b0;
      if (c == 7) begin
        fetch_addr[0] = 32'h0000_0004;
        fetch_req[0] = 1'b1;
      end
      if (c == 8) fetch_req[0] = 1'b0;
      #1;
      if (c >= 3 && c <= 6) begin
        checks++;
        if ({busy[0], fetch_valid[0], fetch_data[0]} !== {1'b0, 1'b0, 32'h0}) begin
          errors++; $display("FAIL reset_wait c%0d: got busy=%b valid=%b data=%h expected 0/0/00000000",
                             c, busy[0], fetch_valid[0], fetch_data[0]);
        end
      end
      if (c == 10) begin
        checks++;
        if ({fetch_valid[0], fetch_data[0]} !== {1'b1, 32'hA000_0001}) begin
          errors++; $display("FAIL reset_wait_recover: got valid=%b data=%h expected 1/a0000001",
                             fetch_valid[0], fetch_data[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_issue();
    ld_addr[1] = 32'h0000_0010;
    ld_wdata[1] = 32'h5555_AAAA;
    ld_req[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin
        ld_req[1] = 1'b0;
        reset = 1'b1;
      end
      if (c == 2) reset = 1'b0;
      #1;
      if (c >= 2) begin
        checks++;
        if ({mem_en[1], ld_done[1], busy[1]} !== 3'b000) begin
          errors++; $display("FAIL reset_issue c%0d: got mem_en/ld_done/busy %b%b%b expected 000",
                             c, mem_en[1], ld_done[1], busy[1]);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      fetch_addr[i] = 32'h0;
      ld_addr[i] = 32'h0;
      ld_wdata[i] = 32'h0;
    end
    test_reset();
    test_fetch_lat1();
    test_load_lat3();
    test_tie();
    test_busy_hold();
    test_reset_wait();
    test_reset_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
